// File: rtl/obstacle_scroller_pkg.sv
// obstacle_scroller_pkg: state encoding, playfield constants and the LFSR step shared by the scroller.
package obstacle_scroller_pkg;
   typedef enum logic [2:0] {IDLE, PICK, LOAD, SCROLL, GAP} state_e;
   localparam logic [9:0] LANE_X0 = 10'hC5;
   localparam logic [9:0] LANE_X1 = 10'h117;
   localparam logic [9:0] LANE_X2 = 10'h169;
   localparam logic [9:0] SPAWN_Y = 10'h262;
   localparam logic [9:0] HIDDEN_Y = 10'h26C;
   localparam logic [2:0] NUM_PATTERNS = 3'd6;
   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction
endpackage

// File: rtl/obstacle_scroller_if.sv
// obstacle_scroller_if: game control, position ROM and renderer/score signals of the scroller.
interface obstacle_scroller_if;
   logic frame_tick, run, collision;
   logic [3:0] speed;
   logic [2:0] index;
   logic [9:0] x0_in, y0_in, x1_in, y1_in;
   logic en0_in, en1_in;
   logic [9:0] obj_x0, obj_y0, obj_x1, obj_y1;
   logic obj_en0, obj_en1, passed_pulse;
   logic [7:0] pairs_passed;
   modport master (
      output frame_tick, run, collision, speed, x0_in, y0_in, en0_in, x1_in, y1_in, en1_in,
      input index, obj_x0, obj_y0, obj_x1, obj_y1, obj_en0, obj_en1, passed_pulse, pairs_passed
   );
   modport slave (
      input frame_tick, run, collision, speed, x0_in, y0_in, en0_in, x1_in, y1_in, en1_in,
      output index, obj_x0, obj_y0, obj_x1, obj_y1, obj_en0, obj_en1, passed_pulse, pairs_passed
   );
endinterface

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr: 8-bit Fibonacci LFSR stepped once per pattern pick, folded onto pattern indices 0..5.
module obstacle_lfsr
   import obstacle_scroller_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step,
   output logic [2:0] index
);
   logic [7:0] lfsr_q, lfsr_d;
   logic [2:0] index_q, index_d;
   always_comb begin
      lfsr_d = step ? lfsr_next(lfsr_q) : lfsr_q;
      index_d = !step ? index_q : lfsr_d[2:0] >= NUM_PATTERNS ? lfsr_d[2:0] - NUM_PATTERNS : lfsr_d[2:0];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= SEED;
         index_q <= 3'd0;
      end else begin
         lfsr_q <= lfsr_d;
         index_q <= index_d;
      end
   end
   assign index = index_q;
endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: picks obstacle patterns from the position ROM and scrolls each pair
// down the screen, counting retired pairs for the score logic.
module obstacle_scroller
   import obstacle_scroller_pkg::*;
#(
   parameter int         GAP_FRAMES = 16,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input logic clk,
   input logic reset,
   obstacle_scroller_if.slave bus
);
   state_e state_q, state_d;
   logic [9:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d, ny0, ny1;
   logic en0_q, en0_d, en1_q, en1_d, pulse_q, pulse_d, adv, retire, step;
   logic [7:0] gap_q, gap_d, pairs_q, pairs_d;
   logic [2:0] index;
   obstacle_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .step(step), .index(index));
   always_comb begin
      adv = bus.frame_tick && !bus.collision;
      ny0 = y0_q > 10'(bus.speed) ? y0_q - 10'(bus.speed) : 10'd0;
      ny1 = y1_q > 10'(bus.speed) ? y1_q - 10'(bus.speed) : 10'd0;
      // an empty pair retires on the first tick; an enabled one needs motion and all enabled y at 0
      retire = bus.run && state_q == SCROLL && adv && ((en0_q || en1_q) ?
               bus.speed != 4'd0 && (!en0_q || ny0 == 10'd0) && (!en1_q || ny1 == 10'd0) : 1'b1);
      step = bus.run && state_q == PICK;
      state_d = state_q;
      x0_d = x0_q;
      y0_d = y0_q;
      x1_d = x1_q;
      y1_d = y1_q;
      en0_d = en0_q;
      en1_d = en1_q;
      gap_d = gap_q;
      pulse_d = retire;
      pairs_d = retire && pairs_q != 8'hFF ? pairs_q + 8'd1 : pairs_q;
      if (!bus.run) begin
         state_d = IDLE;
         en0_d = 1'b0;
         en1_d = 1'b0;
         gap_d = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = PICK;
               pairs_d = 8'd0;
            end
            PICK: state_d = LOAD;
            LOAD: begin
               {x0_d, y0_d, en0_d} = {bus.x0_in, bus.y0_in, bus.en0_in};
               {x1_d, y1_d, en1_d} = {bus.x1_in, bus.y1_in, bus.en1_in};
               state_d = SCROLL;
            end
            SCROLL: if (adv) begin
               y0_d = ny0;
               y1_d = ny1;
               if (retire) begin
                  en0_d = 1'b0;
                  en1_d = 1'b0;
                  state_d = GAP;
               end
            end
            GAP: if (adv) begin
               gap_d = gap_q + 8'd1;
               if (gap_d == 8'(GAP_FRAMES)) begin
                  gap_d = 8'd0;
                  state_d = PICK;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         {x0_q, y0_q, x1_q, y1_q} <= '0;
         {en0_q, en1_q, pulse_q} <= '0;
         gap_q <= 8'd0;
         pairs_q <= 8'd0;
      end else begin
         state_q <= state_d;
         {x0_q, y0_q, x1_q, y1_q} <= {x0_d, y0_d, x1_d, y1_d};
         {en0_q, en1_q, pulse_q} <= {en0_d, en1_d, pulse_d};
         gap_q <= gap_d;
         pairs_q <= pairs_d;
      end
   end
   assign bus.index = index;
   assign {bus.obj_x0, bus.obj_y0, bus.obj_x1, bus.obj_y1} = {x0_q, y0_q, x1_q, y1_q};
   assign {bus.obj_en0, bus.obj_en1, bus.passed_pulse} = {en0_q, en1_q, pulse_q};
   assign bus.pairs_passed = pairs_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: directed vectors, hand sequences and a random run against a pair-level model,
// plus a saturation run on a GAP_FRAMES=1 instance.
module tb_obstacle_scroller;
   import obstacle_scroller_pkg::*;
   typedef struct packed {logic [9:0] x0, y0; logic en0; logic [9:0] x1, y1; logic en1;} rom_t;
   typedef struct {
      logic run, tick, coll; logic [3:0] spd;
      logic [2:0] idx; logic en0, en1, pulse; logic [9:0] x0, y0, x1;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, rom_off = 1'b0;
   int checks = 0, passes = 0;
   int m_ph, m_gap, m_pairs;
   logic [7:0] m_l;
   logic [2:0] m_idx;
   logic [9:0] m_x0, m_y0, m_x1, m_y1;
   logic m_e0, m_e1, m_pulse;
   obstacle_scroller_if a ();
   obstacle_scroller_if b ();
   obstacle_scroller dut (.clk(clk), .reset(reset), .bus(a));
   obstacle_scroller #(.GAP_FRAMES(1)) dut2 (.clk(clk), .reset(reset), .bus(b));
   always #5 clk = ~clk;
   function automatic rom_t rom(input logic [2:0] i, input logic off);
      rom_t r;
      case (i)
         3'd0: r = {LANE_X0, SPAWN_Y, 1'b1, LANE_X1, SPAWN_Y, 1'b1};
         3'd1: r = {LANE_X0, SPAWN_Y, 1'b1, LANE_X2, SPAWN_Y, 1'b1};
         3'd2: r = {LANE_X1, SPAWN_Y, 1'b1, LANE_X2, SPAWN_Y, 1'b1};
         3'd3: r = {LANE_X0, SPAWN_Y, 1'b1, 10'd0, HIDDEN_Y, 1'b0};
         3'd4: r = {LANE_X2, SPAWN_Y, 1'b1, 10'd0, HIDDEN_Y, 1'b0};
         3'd5: r = {LANE_X1, SPAWN_Y, 1'b1, 10'd0, HIDDEN_Y, 1'b0};
         default: r = '0;
      endcase
      if (off) {r.en0, r.en1, r.y0, r.y1} = {1'b0, 1'b0, HIDDEN_Y, HIDDEN_Y};
      return r;
   endfunction
   assign {a.x0_in, a.y0_in, a.en0_in, a.x1_in, a.y1_in, a.en1_in} = rom(a.index, rom_off);
   assign {b.x0_in, b.y0_in, b.en0_in, b.x1_in, b.y1_in, b.en1_in} = rom(b.index, 1'b0);
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask
   function automatic logic [63:0] outs_a();
      return {a.index, a.obj_en0, a.obj_en1, a.passed_pulse, a.pairs_passed,
              a.obj_x0, a.obj_y0, a.obj_x1, a.obj_y1};
   endfunction
   function automatic logic [63:0] exp_a();
      return {m_idx, m_e0, m_e1, m_pulse, 8'(m_pairs), m_x0, m_y0, m_x1, m_y1};
   endfunction
   task automatic cyc(input logic run, input logic tick, input logic coll, input logic [3:0] spd);
      {a.run, a.frame_tick, a.collision, a.speed} = {run, tick, coll, spd};
      @(posedge clk);
      #1;
   endtask
   task automatic model_reset();
      {m_ph, m_gap, m_pairs} = {32'd0, 32'd0, 32'd0};
      m_l = 8'hA5;
      {m_idx, m_x0, m_y0, m_x1, m_y1, m_e0, m_e1, m_pulse} = '0;
   endtask
   // pair-level behaviour: phase 0 idle, 1 pick, 2 load, 3 scroll, 4 gap
   task automatic model(input logic run, input logic tick, input logic coll, input logic [3:0] spd);
      rom_t r;
      logic adv;
      adv = tick && !coll;
      m_pulse = 1'b0;
      if (!run) begin
         m_ph = 0; m_gap = 0; m_e0 = 1'b0; m_e1 = 1'b0;
      end else if (m_ph == 0) begin
         m_ph = 1; m_pairs = 0;
      end else if (m_ph == 1) begin
         m_l = {m_l[6:0], m_l[7] ^ m_l[5] ^ m_l[4] ^ m_l[3]};
         m_idx = 3'(m_l[2:0] % 3'd6);
         m_ph = 2;
      end else if (m_ph == 2) begin
         r = rom(m_idx, rom_off);
         {m_x0, m_y0, m_e0, m_x1, m_y1, m_e1} = r;
         m_ph = 3;
      end else if (m_ph == 3 && adv) begin
         m_y0 = m_y0 > {6'd0, spd} ? m_y0 - {6'd0, spd} : 10'd0;
         m_y1 = m_y1 > {6'd0, spd} ? m_y1 - {6'd0, spd} : 10'd0;
         if ((!m_e0 || m_y0 == 10'd0) && (!m_e1 || m_y1 == 10'd0)) begin
            m_e0 = 1'b0; m_e1 = 1'b0; m_pulse = 1'b1;
            m_pairs = m_pairs < 255 ? m_pairs + 1 : 255;
            m_ph = 4;
         end
      end else if (m_ph == 4 && adv) begin
         m_gap++;
         if (m_gap == 16) begin
            m_gap = 0; m_ph = 1;
         end
      end
   endtask
   initial begin
      vec_t tv[8];
      int q, n, cyc_n;
      logic c, bad, r_run, r_tick, r_coll;
      logic [3:0] r_spd;
      tv[0] = '{1'b1, 1'b0, 1'b0, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0};
      tv[1] = '{1'b1, 1'b1, 1'b0, 4'd2, 3'd2, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd0};
      tv[2] = '{1'b1, 1'b1, 1'b0, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h262, 10'h169};
      tv[3] = '{1'b1, 1'b1, 1'b0, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h260, 10'h169};
      tv[4] = '{1'b1, 1'b1, 1'b1, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h260, 10'h169};
      tv[5] = '{1'b1, 1'b0, 1'b0, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h260, 10'h169};
      tv[6] = '{1'b1, 1'b1, 1'b0, 4'd5, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h25B, 10'h169};
      tv[7] = '{1'b1, 1'b1, 1'b0, 4'd0, 3'd2, 1'b1, 1'b1, 1'b0, 10'h117, 10'h25B, 10'h169};
      {a.run, a.frame_tick, a.collision, a.speed} = '0;
      {b.run, b.frame_tick, b.collision, b.speed} = '0;
      @(posedge clk);
      #1;
      chk("reset_state", outs_a(), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc(tv[i].run, tv[i].tick, tv[i].coll, tv[i].spd);
         chk($sformatf("vec%0d", i),
             {a.index, a.obj_en0, a.obj_en1, a.passed_pulse, a.obj_x0, a.obj_y0, a.obj_x1},
             {tv[i].idx, tv[i].en0, tv[i].en1, tv[i].pulse, tv[i].x0, tv[i].y0, tv[i].x1});
      end
      for (int k = 1; k <= 201; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'd3);
         chk("p1_scroll", {a.passed_pulse, a.obj_en0, a.obj_y0, a.obj_y1},
             {k == 201, k != 201, 10'(603 - 3 * k), 10'(603 - 3 * k)});
      end
      cyc(1'b1, 1'b0, 1'b0, 4'd3);
      chk("p1_pulse_once", {a.passed_pulse, a.pairs_passed}, {1'b0, 8'd1});
      for (int k = 0; k < 65; k++) cyc(1'b1, 1'b1, k >= 8 && k < 58, 4'd2);
      cyc(1'b1, 1'b0, 1'b0, 4'd2);
      chk("gap_frozen", {a.index, a.obj_en0}, {3'd2, 1'b0});
      cyc(1'b1, 1'b1, 1'b0, 4'd2);
      cyc(1'b1, 1'b0, 1'b0, 4'd2);
      chk("index2", a.index, 3'd5);
      cyc(1'b1, 1'b0, 1'b0, 4'd2);
      chk("load2", {a.obj_en0, a.obj_en1, a.obj_x0, a.obj_y0}, {1'b1, 1'b0, 10'h117, 10'h262});
      for (int k = 1; k <= 355; k++) begin
         c = k > 100 && k <= 150;
         cyc(1'b1, 1'b1, c, 4'd2);
         q = k <= 100 ? k : k <= 150 ? 100 : k - 50;
         chk("p2_scroll", {a.passed_pulse, a.obj_y0}, {k == 355, 10'(610 - 2 * q)});
      end
      cyc(1'b1, 1'b0, 1'b0, 4'd2);
      chk("p2_count", a.pairs_passed, 8'd2);
      for (int k = 0; k < 16; k++) cyc(1'b1, 1'b1, 1'b0, 4'd2);
      cyc(1'b1, 1'b0, 1'b0, 4'd3);
      chk("index3", a.index, 3'd2);
      cyc(1'b1, 1'b0, 1'b0, 4'd3);
      for (int k = 1; k <= 204; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'd3);
         q = 610 > 3 * k ? 610 - 3 * k : 0;
         chk("p3_sat", {a.passed_pulse, a.obj_y0, a.obj_y1}, {k == 204, 10'(q), 10'(q)});
      end
      for (int k = 0; k < 17; k++) cyc(1'b1, k > 0, 1'b0, 4'd3);
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      chk("index4", {a.index, a.pairs_passed}, {3'd4, 8'd3});
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      chk("load4", {a.obj_en0, a.obj_en1, a.obj_x0}, {1'b1, 1'b0, 10'h169});
      for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, 1'b0, 4'd4);
      cyc(1'b0, 1'b1, 1'b0, 4'd4);
      chk("run_drop", {a.obj_en0, a.obj_en1, a.passed_pulse, a.obj_y0, a.pairs_passed},
          {1'b0, 1'b0, 1'b0, 10'd570, 8'd3});
      cyc(1'b0, 1'b0, 1'b0, 4'd4);
      chk("idle_hold", {a.passed_pulse, a.index}, {1'b0, 3'd4});
      rom_off = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      chk("rerun_clear", a.pairs_passed, 8'd0);
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      chk("no_reseed", a.index, 3'd1);
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      chk("load_empty", {a.obj_en0, a.obj_en1, a.obj_x0}, {1'b0, 1'b0, 10'hC5});
      rom_off = 1'b0;
      cyc(1'b1, 1'b0, 1'b0, 4'd4);
      cyc(1'b1, 1'b1, 1'b1, 4'd4);
      chk("empty_wait", a.passed_pulse, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 4'd4);
      chk("empty_retire", {a.passed_pulse, a.pairs_passed}, {1'b1, 8'd1});
      reset = 1'b1;
      #1;
      chk("reset_mid", outs_a(), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4000; i++) begin
         r_run = $urandom_range(0, 299) != 0;
         r_tick = $urandom_range(0, 1) == 1;
         r_coll = $urandom_range(0, 7) == 0;
         r_spd = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 40) == 0) rom_off = !rom_off;
         model(r_run, r_tick, r_coll, r_spd);
         cyc(r_run, r_tick, r_coll, r_spd);
         chk("rand", outs_a(), exp_a());
      end
      {a.run, a.frame_tick, a.collision} = '0;
      {b.run, b.frame_tick, b.collision, b.speed} = {1'b1, 1'b1, 1'b0, 4'd15};
      n = 0;
      cyc_n = 0;
      bad = 1'b0;
      while (n < 300 && cyc_n < 20000) begin
         @(posedge clk);
         #1;
         cyc_n++;
         if (b.index > 3'd5) bad = 1'b1;
         if (b.passed_pulse) begin
            n++;
            chk("sat_count", b.pairs_passed, n > 255 ? 255 : n);
         end
      end
      chk("sat_done", n, 300);
      chk("idx_range", bad, 1'b0);
      reset = 1'b1;
      #1;
      chk("reset_gap", {b.index, b.obj_en0, b.obj_en1, b.passed_pulse, b.pairs_passed,
                        b.obj_x0, b.obj_y0, b.obj_x1, b.obj_y1}, 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
